// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: load-first with ALU anti-starvation,
// load data sign/zero extension and registered write strobe.
module regfile_wb_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [5:0]  ld_opcode,
    input  logic [4:0]  ld_rt,
    input  logic [4:0]  ld_rd,
    input  logic        ld_regdst,
    input  logic [31:0] ld_data,
    output logic        wr_en,
    output logic [4:0]  wr_addr,
    output logic [31:0] wr_data,
    output logic        illegal_op
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;

    logic [CNT_W-1:0] starve_cnt;
    logic             grant_alu;
    logic             grant_ld;
    logic             starved;
    logic [4:0]       ld_dest;
    logic [31:0]      ld_fmt;
    logic             ld_legal;

    assign starved   = (starve_cnt >= LIMIT);
    assign grant_alu = alu_valid && (!ld_valid || starved);
    assign grant_ld  = ld_valid && !grant_alu;

    // Readies are gated by reset so nothing is accepted while held in reset.
    assign alu_ready = rst_n && grant_alu;
    assign ld_ready  = rst_n && grant_ld;

    assign ld_dest = ld_regdst ? ld_rd : ld_rt;

    always_comb begin
        ld_fmt   = ld_data;
        ld_legal = 1'b1;
        case (ld_opcode)
            OP_LB:   ld_fmt = {{24{ld_data[7]}}, ld_data[7:0]};
            OP_LBU:  ld_fmt = {24'h0, ld_data[7:0]};
            OP_LH:   ld_fmt = {{16{ld_data[15]}}, ld_data[15:0]};
            OP_LHU:  ld_fmt = {16'h0, ld_data[15:0]};
            OP_LW:   ld_fmt = ld_data;
            default: ld_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (!alu_valid || grant_alu) begin
            starve_cnt <= '0;
        end else if (starve_cnt < LIMIT) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Writes to r0 and illegal loads are consumed without touching addr/data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            illegal_op <= 1'b0;
        end else begin
            wr_en      <= 1'b0;
            illegal_op <= 1'b0;
            if (grant_alu) begin
                if (alu_rd != 5'd0) begin
                    wr_en   <= 1'b1;
                    wr_addr <= alu_rd;
                    wr_data <= alu_data;
                end
            end else if (grant_ld) begin
                if (!ld_legal) begin
                    illegal_op <= 1'b1;
                end else if (ld_dest != 5'd0) begin
                    wr_en   <= 1'b1;
                    wr_addr <= ld_dest;
                    wr_data <= ld_fmt;
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: extension, r0 drop,
// illegal opcodes, starvation pattern and async reset.
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [5:0]  ld_opcode;
    logic [4:0]  ld_rt;
    logic [4:0]  ld_rd;
    logic        ld_regdst;
    logic [31:0] ld_data;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        illegal_op;

    int n_tests;
    int n_fail;

    regfile_wb_arbiter #(.STARVE_LIMIT(4), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready),
        .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_opcode(ld_opcode), .ld_rt(ld_rt), .ld_rd(ld_rd),
        .ld_regdst(ld_regdst), .ld_data(ld_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .illegal_op(illegal_op)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic alu_req(input logic [4:0] rd, input logic [31:0] d);
        alu_valid = 1'b1;
        alu_rd    = rd;
        alu_data  = d;
        #1;
        check("alu_ready", 32'(alu_ready), 32'd1);
        check("ld_ready_idle", 32'(ld_ready), 32'd0);
        @(posedge clk);
        #1;
        alu_valid = 1'b0;
    endtask

    task automatic ld_req(input logic [5:0] op, input logic [4:0] rt,
                          input logic [4:0] rd, input logic regdst,
                          input logic [31:0] d);
        ld_valid  = 1'b1;
        ld_opcode = op;
        ld_rt     = rt;
        ld_rd     = rd;
        ld_regdst = regdst;
        ld_data   = d;
        #1;
        check("ld_ready", 32'(ld_ready), 32'd1);
        @(posedge clk);
        #1;
        ld_valid = 1'b0;
    endtask

    initial begin
        logic exp_a;
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        alu_valid = 1'b1;
        alu_rd    = 5'd0;
        alu_data  = '0;
        ld_valid  = 1'b1;
        ld_opcode = '0;
        ld_rt     = '0;
        ld_rd     = '0;
        ld_regdst = 1'b0;
        ld_data   = '0;
        #3;
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", wr_data, 32'd0);
        check("rst_illegal", 32'(illegal_op), 32'd0);
        check("rst_alu_ready", 32'(alu_ready), 32'd0);
        check("rst_ld_ready", 32'(ld_ready), 32'd0);
        alu_valid = 1'b0;
        ld_valid  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ALU pass-through
        alu_req(5'd5, 32'h12345678);
        check("alu_wr_en", 32'(wr_en), 32'd1);
        check("alu_wr_addr", 32'(wr_addr), 32'd5);
        check("alu_wr_data", wr_data, 32'h12345678);
        check("alu_illegal", 32'(illegal_op), 32'd0);
        @(posedge clk);
        #1;
        check("alu_wr_en_drop", 32'(wr_en), 32'd0);
        check("alu_addr_hold", 32'(wr_addr), 32'd5);

        // LBU / LB
        ld_req(6'h24, 5'd2, 5'd14, 1'b1, 32'h0054B0AB);
        check("lbu_wr_en", 32'(wr_en), 32'd1);
        check("lbu_addr", 32'(wr_addr), 32'd14);
        check("lbu_data", wr_data, 32'h000000AB);
        ld_req(6'h20, 5'd2, 5'd14, 1'b1, 32'h0054B0AB);
        check("lb_data", wr_data, 32'hFFFFFFAB);

        // LHU to r0 dropped, then LH
        ld_req(6'h25, 5'd0, 5'd9, 1'b0, 32'h0000FFFF);
        check("r0_wr_en", 32'(wr_en), 32'd0);
        check("r0_addr_hold", 32'(wr_addr), 32'd14);
        check("r0_data_hold", wr_data, 32'hFFFFFFAB);
        ld_req(6'h21, 5'd3, 5'd9, 1'b0, 32'h00008001);
        check("lh_wr_en", 32'(wr_en), 32'd1);
        check("lh_addr", 32'(wr_addr), 32'd3);
        check("lh_data", wr_data, 32'hFFFF8001);
        ld_req(6'h25, 5'd4, 5'd9, 1'b0, 32'h12348001);
        check("lhu_data", wr_data, 32'h00008001);
        ld_req(6'h23, 5'd1, 5'd7, 1'b1, 32'hDEADBEEF);
        check("lw_addr", 32'(wr_addr), 32'd7);
        check("lw_data", wr_data, 32'hDEADBEEF);

        // ALU to r0
        alu_req(5'd0, 32'hCAFEF00D);
        check("alu_r0_wr_en", 32'(wr_en), 32'd0);
        check("alu_r0_data", wr_data, 32'hDEADBEEF);

        // Illegal opcode
        ld_req(6'h2F, 5'd9, 5'd9, 1'b0, 32'h55555555);
        check("ill_pulse", 32'(illegal_op), 32'd1);
        check("ill_wr_en", 32'(wr_en), 32'd0);
        check("ill_addr_hold", 32'(wr_addr), 32'd7);
        @(posedge clk);
        #1;
        check("ill_pulse_end", 32'(illegal_op), 32'd0);

        // Contention: L,L,L,L,A repeating
        alu_valid = 1'b1;
        alu_rd    = 5'd10;
        alu_data  = 32'hA0A0A0A0;
        ld_valid  = 1'b1;
        ld_opcode = 6'h23;
        ld_regdst = 1'b1;
        ld_rd     = 5'd11;
        ld_data   = 32'h11111111;
        for (int i = 0; i < 10; i++) begin
            exp_a = (i == 4) || (i == 9);
            #1;
            check($sformatf("arb_alu_%0d", i), 32'(alu_ready), 32'(exp_a));
            check($sformatf("arb_ld_%0d", i), 32'(ld_ready), 32'(!exp_a));
            @(posedge clk);
            #1;
            check($sformatf("arb_addr_%0d", i), 32'(wr_addr),
                  exp_a ? 32'd10 : 32'd11);
            check($sformatf("arb_cnt_%0d", i),
                  32'(dut.starve_cnt <= 4'd4), 32'd1);
        end

        // Build starvation, then reset mid-write
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
        end
        #1;
        check("pre_rst_wr_en", 32'(wr_en), 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_wr_en", 32'(wr_en), 32'd0);
        check("arst_addr", 32'(wr_addr), 32'd0);
        check("arst_data", wr_data, 32'd0);
        check("arst_alu_ready", 32'(alu_ready), 32'd0);
        check("arst_ld_ready", 32'(ld_ready), 32'd0);
        @(posedge clk);
        #1;
        check("arst_hold_wr_en", 32'(wr_en), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exp_a = (i == 4);
            #1;
            check($sformatf("post_alu_%0d", i), 32'(alu_ready), 32'(exp_a));
            @(posedge clk);
            #1;
        end
        alu_valid = 1'b0;
        ld_valid  = 1'b0;
        @(posedge clk);
        #1;
        check("idle_wr_en", 32'(wr_en), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
